// File: rtl/ps2_host_ctl.sv
// PS/2 host-to-device command controller: transmits a command byte (and optional
// argument) with the host-to-device handshake, then collects the keyboard response.
module ps2_host_ctl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    input  logic [7:0] rx_code,
    input  logic       rx_rdy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] last_rsp
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_LACK    = 3'd4;
    localparam logic [2:0] S_WAITRSP = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_FAIL    = 3'd7;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 2);

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    logic          clk_meta_q, clk_sync_q, clk_prev_q, fall_q;
    logic          data_meta_q, data_sync_q;
    logic [2:0]    state_q, state_d;
    logic [7:0]    cur_q, cur_d;
    logic [7:0]    arg_q, arg_d;
    logic [7:0]    last_rsp_q, last_rsp_d;
    logic          has_arg_q, has_arg_d;
    logic          phase_q, phase_d;
    logic          data_oe_q, data_oe_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit, resend, dev_wait;

    // Idle lines are high, so the synchronisers reset to 1 to avoid a spurious fall.
    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            fall_q      <= 1'b0;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            fall_q      <= clk_prev_q & ~clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign dev_wait    = (state_q == S_SEND) || (state_q == S_LACK) || (state_q == S_WAITRSP);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        arg_d      = arg_q;
        has_arg_d  = has_arg_q;
        phase_d    = phase_q;
        retry_d    = retry_q;
        bit_cnt_d  = bit_cnt_q;
        data_oe_d  = data_oe_q;
        last_rsp_d = last_rsp_q;
        resend     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cur_d     = cmd_byte;
                    arg_d     = cmd_arg;
                    has_arg_d = cmd_has_arg;
                    phase_d   = 1'b0;
                    retry_d   = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = S_RTS;
            end
            S_RTS: begin
                bit_cnt_d = 4'd0;
                data_oe_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (fall_q) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~cur_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        // Odd parity bit is ~^cur_q; the pull-down drives its inverse.
                        data_oe_d = ^cur_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_LACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAIL;
                end
            end
            S_LACK: begin
                if (fall_q) begin
                    if (!data_sync_q) state_d = S_WAITRSP;
                    else              resend  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_FAIL;
                end
            end
            S_WAITRSP: begin
                if (rx_rdy) begin
                    last_rsp_d = rx_code;
                    if (rx_code == RSP_ACK) begin
                        if (!phase_q && has_arg_q) begin
                            phase_d = 1'b1;
                            cur_d   = arg_q;
                            retry_d = '0;
                            state_d = S_INHIBIT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (rx_code == RSP_RESEND) begin
                        resend = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (timeout_hit) begin
                    state_d = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (resend) begin
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = S_INHIBIT;
            end else begin
                state_d = S_FAIL;
            end
        end

        // Device clock edges only extend the deadline while waiting on the device.
        if (state_q == S_IDLE || state_d != state_q || (dev_wait && fall_q)) cnt_d = '0;
        else                                                                  cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cur_q      <= 8'h00;
            arg_q      <= 8'h00;
            has_arg_q  <= 1'b0;
            phase_q    <= 1'b0;
            retry_q    <= '0;
            bit_cnt_q  <= 4'd0;
            data_oe_q  <= 1'b0;
            last_rsp_q <= 8'h00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            arg_q      <= arg_d;
            has_arg_q  <= has_arg_d;
            phase_q    <= phase_d;
            retry_q    <= retry_d;
            bit_cnt_q  <= bit_cnt_d;
            data_oe_q  <= data_oe_d;
            last_rsp_q <= last_rsp_d;
            cnt_q      <= cnt_d;
        end
    end

    // Line enables decode straight from state so reset releases the bus at once.
    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = ~cmd_ready;
    assign rx_inhibit  = ~cmd_ready;
    assign done        = (state_q == S_DONE);
    assign err         = (state_q == S_FAIL);
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
    assign ps2_data_oe = (state_q == S_RTS) || ((state_q == S_SEND) && data_oe_q);
    assign last_rsp    = last_rsp_q;
endmodule

// File: tb/tb_ps2_host_ctl.sv
// Bench for ps2_host_ctl: a PS/2 keyboard model clocks each host frame, returns a
// line ACK/NAK and a scripted response byte; outcomes are compared with a command-level model.
module tb_ps2_host_ctl;
    localparam int INH = 50;
    localparam int TO  = 400;
    localparam int MR  = 3;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic [7:0] rx_code = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       cmd_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, done, err;
    logic [7:0] last_rsp;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    // Open-drain lines: either side may pull low.
    assign ps2_clk_in  = !ps2_clk_oe && !dev_clk_low;
    assign ps2_data_in = !ps2_data_oe && !dev_data_low;

    ps2_host_ctl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
        .rx_code(rx_code), .rx_rdy(rx_rdy), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit),
        .busy(busy), .done(done), .err(err), .last_rsp(last_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic        has_arg;
        logic [7:0]  arg;
        logic [63:0] rsps;
        int          nrsp;
        logic [15:0] naks;
        int          exp_frames;
        logic        exp_done;
        logic [7:0]  exp_last;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0, err_cnt = 0, err_cyc = 0, send_cyc = 0;
    int          inh_run = 0, rts_run = 0;
    int          dev_bit = 0, dev_frame_idx = 0, dev_rsp_idx = 0, dev_nrsp = 0;
    bit          rts_go = 0, dev_no_clock = 0, dev_abort = 0;
    logic [63:0] dev_rsps = '0;
    logic [15:0] dev_naks = '0;
    logic [7:0]  got_frames[$];
    bit          got_par[$];
    logic [7:0]  exp_frames[$];
    logic [7:0]  model_last = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and the inhibit/request-to-send shape seen before each frame.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (ps2_clk_oe) begin
            inh_run++;
            if (ps2_data_oe) rts_run++;
        end else begin
            if (inh_run != 0 && ps2_data_oe) begin
                check("inhibit_len", inh_run, INH + 1);
                check("rts_len", rts_run, 1);
                send_cyc = cyc;
                rts_go   = 1;
            end
            inh_run = 0;
            rts_run = 0;
        end
    end

    task automatic dev_frame();
        logic [10:0] bits;
        bit          nak;
        bits    = '0;
        bits[0] = ps2_data_in;
        dev_bit = 0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_bit     = k;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (dev_abort) return;
            repeat (H) @(negedge clk);
            if (dev_abort) return;
            bits[k] = ps2_data_in;
        end
        nak          = dev_naks[dev_frame_idx];
        dev_data_low = !nak;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        got_frames.push_back(bits[8:1]);
        got_par.push_back(bits[9]);
        check("frame_start_bit", bits[0], 1'b0);
        check("frame_odd_parity", ^bits[9:1], 1'b1);
        check("frame_stop_bit", bits[10], 1'b1);
        dev_frame_idx++;
        if (!nak && dev_rsp_idx < dev_nrsp) begin
            repeat (10) @(negedge clk);
            rx_code = dev_rsps[8*dev_rsp_idx +: 8];
            rx_rdy  = 1'b1;
            @(negedge clk);
            rx_rdy = 1'b0;
            dev_rsp_idx++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rts_go) begin
                rts_go = 0;
                if (!dev_no_clock && !dev_abort) dev_frame();
            end
        end
    end

    // Command-level reference: walks the byte list, retry budget and response rules.
    task automatic model(input logic [7:0] c, input logic ha, input logic [7:0] a,
                         input logic [63:0] rsps, input int nrsp, input logic [15:0] naks,
                         output bit ok);
        logic [7:0] cur = c;
        logic [7:0] rsp;
        bit on_arg = 0, fin = 0, again;
        int retry = 0, att = 0, r = 0;
        exp_frames.delete();
        ok = 0;
        while (!fin) begin
            exp_frames.push_back(cur);
            again = 0;
            if (naks[att]) begin
                again = 1;
            end else if (r >= nrsp) begin
                fin = 1;
            end else begin
                rsp = rsps[8*r +: 8];
                r++;
                model_last = rsp;
                if (rsp == 8'hFA) begin
                    if (ha && !on_arg) begin
                        on_arg = 1;
                        cur    = a;
                        retry  = 0;
                    end else begin
                        ok  = 1;
                        fin = 1;
                    end
                end else if (rsp == 8'hFE) begin
                    again = 1;
                end else begin
                    fin = 1;
                end
            end
            att++;
            if (again) begin
                if (retry < MR) retry++;
                else            fin = 1;
            end
        end
    endtask

    task automatic start_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a,
                             input logic [63:0] rsps, input int nrsp, input logic [15:0] naks);
        dev_rsps = rsps; dev_nrsp = nrsp; dev_naks = naks;
        dev_frame_idx = 0; dev_rsp_idx = 0; dev_bit = 0;
        got_frames.delete(); got_par.delete();
        done_cnt = 0; err_cnt = 0;
        @(negedge clk);
        check("ready_before_accept", cmd_ready, 1'b1);
        cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_byte = 8'($urandom); cmd_arg = 8'($urandom); cmd_has_arg = 1'($urandom);
        check("clk_oe_after_accept", ps2_clk_oe, 1'b1);
        check("busy_after_accept", busy, 1'b1);
        check("rx_inhibit_after_accept", rx_inhibit, 1'b1);
    endtask

    task automatic wait_end();
        int n = 0;
        while (done_cnt + err_cnt == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("completion_seen", (done_cnt + err_cnt) != 0, 1'b1);
        repeat (30) @(negedge clk);
    endtask

    task automatic compare(input string tag, input int exp_n, input bit exp_ok, input logic [7:0] exp_last);
        check({tag, "_frames"}, got_frames.size(), exp_n);
        for (int i = 0; i < exp_frames.size() && i < got_frames.size(); i++)
            check({tag, "_byte"}, got_frames[i], exp_frames[i]);
        check({tag, "_done"}, done_cnt, exp_ok ? 1 : 0);
        check({tag, "_err"}, err_cnt, exp_ok ? 0 : 1);
        check({tag, "_last_rsp"}, last_rsp, exp_last);
        check({tag, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check({tag, "_ready_after"}, cmd_ready, 1'b1);
    endtask

    initial begin
        vec_t        tbl[9];
        bit          ok;
        logic [7:0]  prev, b, r8;
        logic [63:0] rs;
        logic [15:0] nk;
        logic [7:0]  cmds[7];
        int          n;

        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        bit          ok;
        logic [7:0]  prev, b, r8;
        logic [63:0] rs;
        logic [15:0] nk;
        logic [7:0]  cmds[7];
        int          n;

        tbl[0] = '{8'hED, 1'b1, 8'h02, 64'h0000_0000_0000_FAFA, 2, 16'h0000, 2, 1'b1, 8'hFA};
        tbl[1] = '{8'hF4, 1'b0, 8'h00, 64'h0000_0000_0000_FAFE, 2, 16'h0000, 2, 1'b1, 8'hFA};
        tbl[2] = '{8'hFF, 1'b0, 8'h00, 64'h0000_0000_FEFE_FEFE, 4, 16'h0000, 4, 1'b0, 8'hFE};
        tbl[3] = '{8'hF4, 1'b0, 8'h00, 64'h0000_0000_0000_00FA, 1, 16'h0001, 2, 1'b1, 8'hFA};
        tbl[4] = '{8'hF3, 1'b1, 8'h20, 64'h0000_0000_00FA_FEFA, 3, 16'h0000, 3, 1'b1, 8'hFA};
        tbl[5] = '{8'hEE, 1'b0, 8'h00, 64'h0000_0000_0000_00EE, 1, 16'h0000, 1, 1'b0, 8'hEE};
        tbl[6] = '{8'hED, 1'b1, 8'h07, 64'h0000_00FE_FEFE_FEFA, 5, 16'h0000, 5, 1'b0, 8'hFE};
        tbl[7] = '{8'hF3, 1'b1, 8'h0A, 64'h0000_00FA_FAFE_FEFE, 5, 16'h0000, 5, 1'b1, 8'hFA};
        tbl[8] = '{8'hF5, 1'b0, 8'h00, 64'h0000_0000_0000_0000, 0, 16'h000F, 4, 1'b0, 8'hFA};
        cmds = '{8'hED, 8'hF3, 8'hF4, 8'hF5, 8'hFF, 8'hF2, 8'hEE};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_rx_inhibit", rx_inhibit, 1'b0);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_last_rsp", last_rsp, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // LED set with argument, plus a busy-time command and a stray rx_rdy that must be ignored.
        prev = model_last;
        model(8'hED, 1'b1, 8'h02, 64'hFAFA, 2, 16'h0, ok);
        fork
            begin
                start_cmd(8'hED, 1'b1, 8'h02, 64'hFAFA, 2, 16'h0);
                wait_end();
            end
            begin
                repeat (10) @(negedge clk);
                cmd_byte = 8'h55; cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
                rx_code = 8'h11; rx_rdy = 1'b1;
                @(negedge clk);
                rx_rdy = 1'b0;
                @(negedge clk);
                check("stray_rx_ignored", last_rsp, prev);
                check("busy_during_cmd", busy, 1'b1);
            end
        join
        compare("led_set", exp_frames.size(), ok, model_last);
        if (got_par.size() == 2) begin
            check("led_parity_cmd", got_par[0], 1'b1);
            check("led_parity_arg", got_par[1], 1'b0);
        end else begin
            check("led_parity_frames", got_par.size(), 2);
        end

        for (int i = 0; i < 9; i++) begin
            model(tbl[i].cmd, tbl[i].has_arg, tbl[i].arg, tbl[i].rsps, tbl[i].nrsp, tbl[i].naks, ok);
            start_cmd(tbl[i].cmd, tbl[i].has_arg, tbl[i].arg, tbl[i].rsps, tbl[i].nrsp, tbl[i].naks);
            wait_end();
            compare($sformatf("vec%0d", i), tbl[i].exp_frames, tbl[i].exp_done, tbl[i].exp_last);
        end

        // Device never clocks: the deadline counts from SEND entry.
        prev = model_last;
        dev_no_clock = 1;
        start_cmd(8'hF2, 1'b0, 8'h00, 64'h0, 0, 16'h0);
        wait_end();
        dev_no_clock = 0;
        check("timeout_err", err_cnt, 1);
        check("timeout_no_done", done_cnt, 0);
        check("timeout_latency", err_cyc - send_cyc, TO);
        check("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("timeout_last_rsp", last_rsp, prev);

        // Reset while data bit 4 of 0xED is on the line.
        b = 8'hED;
        start_cmd(8'hED, 1'b1, 8'h02, 64'hFAFA, 2, 16'h0);
        n = 0;
        while (dev_bit != 5 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_bit4", dev_bit, 5);
        repeat (6) @(negedge clk);
        check("pre_reset_data_oe", ps2_data_oe, !b[4]);
        #2 reset_n = 1'b0;
        dev_abort = 1;
        #1;
        check("reset_clk_oe_async", ps2_clk_oe, 1'b0);
        check("reset_data_oe_async", ps2_data_oe, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        dev_abort = 0;
        model_last = 8'h00;
        check("post_reset_ready", cmd_ready, 1'b1);
        check("post_reset_no_pulses", done_cnt + err_cnt, 0);
        check("post_reset_last_rsp", last_rsp, 8'h00);
        model(8'hED, 1'b1, 8'h02, 64'hFAFA, 2, 16'h0, ok);
        start_cmd(8'hED, 1'b1, 8'h02, 64'hFAFA, 2, 16'h0);
        wait_end();
        compare("after_reset", exp_frames.size(), ok, model_last);

        for (int t = 0; t < 10; t++) begin
            rs = '0;
            for (int j = 0; j < 8; j++) begin
                n = $urandom_range(0, 9);
                r8 = (n < 5) ? 8'hFA : (n < 9) ? 8'hFE : (n[0] ? 8'hAA : 8'hEE);
                rs[8*j +: 8] = r8;
            end
            nk = '0;
            for (int j = 0; j < 16; j++) nk[j] = ($urandom_range(0, 7) == 0);
            b  = cmds[$urandom_range(0, 6)];
            r8 = 8'($urandom);
            n  = $urandom_range(0, 1);
            model(b, n[0], r8, rs, 8, nk, ok);
            start_cmd(b, n[0], r8, rs, 8, nk);
            wait_end();
            compare($sformatf("rand%0d", t), exp_frames.size(), ok, model_last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
